// File: rtl/sequence_compare.sv
// Round checker: compares player colour guesses against a latched 15-bit sequence,
// one 3-bit group per guess, and reports pass/fail, a fail reason and a saturating score.
module sequence_compare #(
  parameter int NUM_COLOURS    = 5,
  parameter int TIMEOUT_CYCLES = 150000000,
  parameter int TIMEOUT_W      = 28
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3*NUM_COLOURS-1:0] sequence_in,
  input  logic [2:0]               round_len,
  input  logic                     guess_valid,
  input  logic [2:0]               guess,
  output logic                     busy,
  output logic [2:0]               guess_idx,
  output logic [2:0]               expected,
  output logic                     round_pass,
  output logic                     round_fail,
  output logic [1:0]               fail_code,
  output logic [3:0]               score,
  input  logic                     score_clr
);

  localparam int SEQ_W = 3 * NUM_COLOURS;
  localparam logic [2:0] MAX_LEN = 3'(NUM_COLOURS);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GUESS,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  // Handshake: start and guess_valid are single-cycle pulses with no back-pressure.
  // start is taken only in IDLE, guess_valid only in WAIT_GUESS; elsewhere they are dropped.

  state_t               state, state_n;
  logic [SEQ_W-1:0]     seq_reg, seq_n;
  logic [2:0]           len_reg, len_n;
  logic [2:0]           idx, idx_n;
  logic [2:0]           guess_reg, guess_n;
  logic [1:0]           fail_code_reg, fail_code_n;
  logic [3:0]           score_reg, score_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;

  logic [SEQ_W-1:0]     seq_shift;
  logic                 last_group;
  logic [2:0]           len_clamped;

  assign seq_shift  = seq_reg >> ({2'b00, idx} * 5'd3);
  assign last_group = (idx + 3'd1) == len_reg;

  always_comb begin
    len_clamped = round_len;
    if (round_len == 3'd0) begin
      len_clamped = 3'd1;
    end else if (round_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      seq_reg       <= '0;
      len_reg       <= '0;
      idx           <= '0;
      guess_reg     <= '0;
      fail_code_reg <= FC_NONE;
      score_reg     <= '0;
      timer         <= '0;
    end else begin
      state         <= state_n;
      seq_reg       <= seq_n;
      len_reg       <= len_n;
      idx           <= idx_n;
      guess_reg     <= guess_n;
      fail_code_reg <= fail_code_n;
      score_reg     <= score_n;
      timer         <= timer_n;
    end
  end

  always_comb begin
    state_n     = state;
    seq_n       = seq_reg;
    len_n       = len_reg;
    idx_n       = idx;
    guess_n     = guess_reg;
    fail_code_n = fail_code_reg;
    score_n     = score_reg;
    timer_n     = timer;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          seq_n       = sequence_in;
          len_n       = len_clamped;
          idx_n       = 3'd0;
          fail_code_n = FC_NONE;
          timer_n     = '0;
          state_n     = S_WAIT_GUESS;
        end
      end
      S_WAIT_GUESS: begin
        // A guess arriving on the timeout cycle still counts.
        if (guess_valid) begin
          guess_n = guess;
          state_n = S_CHECK;
        end else if (timer == TIMER_LAST) begin
          fail_code_n = FC_TIMEOUT;
          state_n     = S_FAIL;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_CHECK: begin
        if (guess_reg != seq_shift[2:0]) begin
          fail_code_n = FC_MISMATCH;
          state_n     = S_FAIL;
        end else if (last_group) begin
          state_n = S_PASS;
        end else begin
          idx_n   = idx + 3'd1;
          timer_n = '0;
          state_n = S_WAIT_GUESS;
        end
      end
      S_PASS: begin
        if (score_reg != 4'd15) begin
          score_n = score_reg + 4'd1;
        end
        state_n = S_IDLE;
      end
      S_FAIL: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (score_clr) begin
      score_n = '0;
    end
  end

  assign busy       = (state != S_IDLE);
  assign guess_idx  = idx;
  assign expected   = seq_shift[2:0];
  assign round_pass = (state == S_PASS);
  assign round_fail = (state == S_FAIL);
  assign fail_code  = fail_code_reg;
  assign score      = score_reg;

endmodule

// File: tb/tb_sequence_compare.sv
// Directed bench for sequence_compare with a short timeout and the 15'h58D1 sequence
// (groups 1,2,3,4,5 in play order).
module tb_sequence_compare;

  localparam int NUM_COLOURS    = 5;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TIMEOUT_W      = 5;

  logic        clock;
  logic        reset;
  logic        start;
  logic [14:0] sequence_in;
  logic [2:0]  round_len;
  logic        guess_valid;
  logic [2:0]  guess;
  logic        busy;
  logic [2:0]  guess_idx;
  logic [2:0]  expected;
  logic        round_pass;
  logic        round_fail;
  logic [1:0]  fail_code;
  logic [3:0]  score;
  logic        score_clr;

  int n_cmp;
  int n_fail;

  sequence_compare #(
    .NUM_COLOURS   (NUM_COLOURS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .sequence_in(sequence_in),
    .round_len  (round_len),
    .guess_valid(guess_valid),
    .guess      (guess),
    .busy       (busy),
    .guess_idx  (guess_idx),
    .expected   (expected),
    .round_pass (round_pass),
    .round_fail (round_fail),
    .fail_code  (fail_code),
    .score      (score),
    .score_clr  (score_clr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each leaves inputs idle and returns 1 ns after the edge that took them
  task automatic do_start(input logic [2:0] len);
    start     = 1'b1;
    round_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic do_guess(input logic [2:0] g);
    guess_valid = 1'b1;
    guess       = g;
    tick();
    guess_valid = 1'b0;
  endtask

  task automatic pass_round_len1(input string tag, input logic [3:0] exp_score);
    do_start(3'd1);
    do_guess(3'd1);
    tick();
    chk({tag, "_pass"}, 32'(round_pass), 32'd1);
    tick();
    chk({tag, "_score"}, 32'(score), 32'(exp_score));
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    sequence_in = 15'h58D1;
    round_len   = 3'd0;
    guess_valid = 1'b0;
    guess       = 3'd0;
    score_clr   = 1'b0;
    #1;
    tick();
    tick();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(guess_idx), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_pass", 32'(round_pass), 32'd0);
    chk("rst_fail", 32'(round_fail), 32'd0);
    chk("rst_fail_code", 32'(fail_code), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    reset = 1'b1;
    tick();

    // Round 1: len 3, guesses 1,2,3 spaced four cycles apart
    do_start(3'd3);
    chk("r1_busy", 32'(busy), 32'd1);
    chk("r1_expected0", 32'(expected), 32'd1);
    do_guess(3'd1);
    tick(); tick(); tick();
    chk("r1_idx1", 32'(guess_idx), 32'd1);
    chk("r1_expected1", 32'(expected), 32'd2);
    do_guess(3'd2);
    tick(); tick(); tick();
    chk("r1_expected2", 32'(expected), 32'd3);
    do_guess(3'd3);
    chk("r1_check_no_pulse", 32'(round_pass), 32'd0);
    tick();
    chk("r1_pass", 32'(round_pass), 32'd1);
    chk("r1_no_fail", 32'(round_fail), 32'd0);
    tick();
    chk("r1_pass_width", 32'(round_pass), 32'd0);
    chk("r1_score", 32'(score), 32'd1);
    chk("r1_fail_code", 32'(fail_code), 32'd0);
    chk("r1_idle", 32'(busy), 32'd0);
    chk("r1_idx_hold", 32'(guess_idx), 32'd2);

    // Round 2: mismatch on second guess
    do_start(3'd3);
    do_guess(3'd1);
    tick();
    do_guess(3'd4);
    tick();
    chk("r2_fail", 32'(round_fail), 32'd1);
    chk("r2_code", 32'(fail_code), 32'd1);
    chk("r2_idx", 32'(guess_idx), 32'd1);
    tick();
    chk("r2_score", 32'(score), 32'd1);
    chk("r2_fail_width", 32'(round_fail), 32'd0);

    // Round 3: timeout after 16 cycles in WAIT_GUESS
    do_start(3'd2);
    chk("r3_code_cleared", 32'(fail_code), 32'd0);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    chk("r3_not_yet", 32'(round_fail), 32'd0);
    chk("r3_still_busy", 32'(busy), 32'd1);
    tick();
    chk("r3_timeout", 32'(round_fail), 32'd1);
    chk("r3_code", 32'(fail_code), 32'd2);
    tick();
    chk("r3_code_hold", 32'(fail_code), 32'd2);

    // Round 4: guess on the timeout cycle wins
    do_start(3'd2);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    do_guess(3'd1);
    tick();
    chk("r4_no_fail", 32'(round_fail), 32'd0);
    chk("r4_waiting", 32'(busy), 32'd1);
    chk("r4_idx", 32'(guess_idx), 32'd1);
    do_guess(3'd2);
    tick();
    chk("r4_pass", 32'(round_pass), 32'd1);
    tick();
    chk("r4_score", 32'(score), 32'd2);

    // Round 5: round_len 0 clamps to 1
    do_start(3'd0);
    do_guess(3'd1);
    tick();
    chk("r5_pass", 32'(round_pass), 32'd1);
    tick();
    chk("r5_score", 32'(score), 32'd3);

    // Round 6: round_len 7 clamps to 5; extra start/guess during CHECK dropped; sequence_in changes ignored
    do_start(3'd7);
    sequence_in = 15'h0000;
    for (int g = 1; g <= 4; g++) begin
      do_guess(3'(g));
      start       = 1'b1;
      guess_valid = 1'b1;
      guess       = 3'd7;
      tick();
      start       = 1'b0;
      guess_valid = 1'b0;
      chk("r6_no_pulse", 32'({round_pass, round_fail}), 32'd0);
      chk("r6_idx", 32'(guess_idx), 32'(g));
      chk("r6_expected", 32'(expected), 32'(g + 1));
    end
    do_guess(3'd5);
    tick();
    chk("r6_pass", 32'(round_pass), 32'd1);
    tick();
    chk("r6_score", 32'(score), 32'd4);
    sequence_in = 15'h58D1;

    // Score saturation at 15
    for (int s = 5; s <= 15; s++) pass_round_len1("sat", 4'(s));
    pass_round_len1("sat_hold", 4'd15);

    // score_clr together with PASS
    do_start(3'd1);
    do_guess(3'd1);
    tick();
    chk("clr_pass", 32'(round_pass), 32'd1);
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
    chk("clr_score", 32'(score), 32'd0);

    // Reset in the middle of WAIT_GUESS
    pass_round_len1("pre_rst", 4'd1);
    do_start(3'd3);
    do_guess(3'd1);
    tick();
    chk("mid_idx", 32'(guess_idx), 32'd1);
    reset = 1'b0;
    tick();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_idx", 32'(guess_idx), 32'd0);
    chk("mrst_expected", 32'(expected), 32'd0);
    chk("mrst_score", 32'(score), 32'd0);
    chk("mrst_pulses", 32'({round_pass, round_fail}), 32'd0);
    chk("mrst_code", 32'(fail_code), 32'd0);
    tick();
    chk("mrst_pulses2", 32'({round_pass, round_fail}), 32'd0);
    reset = 1'b1;
    tick();
    pass_round_len1("post_rst", 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so a stuck run still terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog time limit reached observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
